// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS control sequencer: steps a shared ALU, register file and unified
// memory through fetch/decode/execute/memory/writeback, with retire and illegal-opcode status.
//
// state | meaning
// ------+-----------------------------------------------------------
//   0   | FETCH   read instruction at PC, PC+4; wait for mem_ready
//   1   | DECODE  register read, branch target precompute
//   2   | MEMADR  effective address = A + sign-ext imm
//   3   | MEMRD   load data read; wait for mem_ready
//   4   | MEMWB   load data to rt; retire
//   5   | MEMWR   store write; wait for mem_ready, then retire
//   6   | EXEC    R-type ALU operation
//   7   | ALUWB   ALU result to rd; retire
//   8   | BRANCH  compare A-B, conditional PC load; retire
//   9   | ADDIEX  A + sign-ext imm
//  10   | ADDIWB  ALU result to rt; retire
module multicycle_control_fsm #(
  parameter int unsigned COUNT_W  = 32,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_ADDI  = 6'b001000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               PCSrc,
  output logic               IorD,
  output logic               MemR,
  output logic               MemW,
  output logic               IRWrite,
  output logic               RegW,
  output logic               MemToReg,
  output logic               regDest,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         ALUout,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] retired,
  output logic               illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
  } state_e;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               illegal_q, illegal_d;
  logic               retire;

  // The branch decision is taken by the datapath through PCWriteCond & zero.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = S_FETCH;
    retire    = 1'b0;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWR: begin
        state_d = mem_ready ? S_FETCH : S_MEMWR;
        retire  = mem_ready;
      end
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default:  state_d = S_FETCH;
    endcase
  end

  assign retired_d = retired_q + {{(COUNT_W-1){1'b0}}, retire};

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 1'b0;
    IorD        = 1'b0;
    MemR        = 1'b0;
    MemW        = 1'b0;
    IRWrite     = 1'b0;
    RegW        = 1'b0;
    MemToReg    = 1'b0;
    regDest     = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    ALUout      = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemR    = 1'b1;
        aluSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: aluSrcB = 2'b11;
      S_MEMADR: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemR = 1'b1;
        IorD = 1'b1;
      end
      S_MEMWB: begin
        RegW     = 1'b1;
        MemToReg = 1'b1;
        regDest  = 1'b1;
      end
      S_MEMWR: begin
        MemW = 1'b1;
        IorD = 1'b1;
      end
      S_EXEC: begin
        aluSrcA = 1'b1;
        ALUout  = 2'b10;
      end
      S_ALUWB:  RegW = 1'b1;
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        ALUout      = 2'b01;
        PCWriteCond = 1'b1;
        PCSrc       = 1'b1;
      end
      S_ADDIEX: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegW    = 1'b1;
        regDest = 1'b1;
      end
      default: ;
    endcase
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

  always_ff @(posedge clk) begin
    if (!reset) assert (!(MemR && MemW));
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: instruction-path model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_multicycle_control_fsm;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, BAD = 6'b111111;

  logic clk = 1'b0;
  logic reset, zero, mem_ready;
  logic [5:0] opcode;

  logic PCWrite, PCWriteCond, PCSrc, IorD, MemR, MemW, IRWrite, RegW, MemToReg, regDest, aluSrcA;
  logic [1:0] aluSrcB, ALUout;
  logic [3:0] state;
  logic [31:0] retired;
  logic illegal;

  logic unused4_pcw, unused4_pcwc, unused4_pcsrc, unused4_iord, unused4_memr, unused4_memw;
  logic unused4_irw, unused4_regw, unused4_m2r, unused4_rdst, unused4_srca, unused4_ill;
  logic [1:0] unused4_srcb, unused4_aluop;
  logic [3:0] state4, retired4;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .IorD(IorD),
    .MemR(MemR), .MemW(MemW), .IRWrite(IRWrite), .RegW(RegW), .MemToReg(MemToReg),
    .regDest(regDest), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .ALUout(ALUout),
    .state(state), .retired(retired), .illegal(illegal)
  );

  multicycle_control_fsm #(.COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(unused4_pcw), .PCWriteCond(unused4_pcwc), .PCSrc(unused4_pcsrc), .IorD(unused4_iord),
    .MemR(unused4_memr), .MemW(unused4_memw), .IRWrite(unused4_irw), .RegW(unused4_regw),
    .MemToReg(unused4_m2r), .regDest(unused4_rdst), .aluSrcA(unused4_srca), .aluSrcB(unused4_srcb),
    .ALUout(unused4_aluop), .state(state4), .retired(retired4), .illegal(unused4_ill)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Model: each instruction is a fixed path of states; waits happen only in 0, 3 and 5.
  int          m_path[5];
  int          m_len;
  int          m_idx;
  logic [31:0] m_ret;
  bit          m_ill;
  bit          started = 0;
  int          memw_hi = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_path = '{0, 1, 0, 0, 0};
      m_len = 2; m_idx = 0; m_ret = 0; m_ill = 0; started = 1;
    end else if (started) begin
      if (m_idx == 0) begin
        if (mem_ready) m_idx = 1;
      end else if (m_idx == 1) begin
        case (opcode)
          LW:      begin m_path = '{0, 1, 2, 3, 4};  m_len = 5; end
          SW:      begin m_path = '{0, 1, 2, 5, 0};  m_len = 4; end
          RT:      begin m_path = '{0, 1, 6, 7, 0};  m_len = 4; end
          BEQ:     begin m_path = '{0, 1, 8, 0, 0};  m_len = 3; end
          ADDI:    begin m_path = '{0, 1, 9, 10, 0}; m_len = 4; end
          default: begin m_path = '{0, 1, 0, 0, 0};  m_len = 0; end
        endcase
        if (m_len == 0) begin m_ill = 1; m_idx = 0; end
        else m_idx = 2;
      end else if ((m_path[m_idx] == 3 || m_path[m_idx] == 5) && !mem_ready) begin
        m_idx = m_idx;
      end else if (m_idx == m_len - 1) begin
        m_ret = m_ret + 1; m_idx = 0;
      end else begin
        m_idx = m_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      automatic int s = m_path[m_idx];
      automatic logic e_pcw = 0, e_pcwc = 0, e_pcsrc = 0, e_iord = 0, e_memr = 0, e_memw = 0;
      automatic logic e_irw = 0, e_regw = 0, e_m2r = 0, e_rdst = 0, e_srca = 0;
      automatic logic [1:0] e_srcb = 0, e_alu = 0;
      case (s)
        0:  begin e_memr = 1; e_srcb = 2'b01; e_irw = mem_ready; e_pcw = mem_ready; end
        1:  e_srcb = 2'b11;
        2:  begin e_srca = 1; e_srcb = 2'b10; end
        3:  begin e_memr = 1; e_iord = 1; end
        4:  begin e_regw = 1; e_m2r = 1; e_rdst = 1; end
        5:  begin e_memw = 1; e_iord = 1; end
        6:  begin e_srca = 1; e_alu = 2'b10; end
        7:  e_regw = 1;
        8:  begin e_srca = 1; e_alu = 2'b01; e_pcwc = 1; e_pcsrc = 1; end
        9:  begin e_srca = 1; e_srcb = 2'b10; end
        10: begin e_regw = 1; e_rdst = 1; end
        default: ;
      endcase
      chk("state", state, s);
      chk("state_w4", state4, s);
      chk("PCWrite", PCWrite, e_pcw);
      chk("PCWriteCond", PCWriteCond, e_pcwc);
      chk("PCSrc", PCSrc, e_pcsrc);
      chk("IorD", IorD, e_iord);
      chk("MemR", MemR, e_memr);
      chk("MemW", MemW, e_memw);
      chk("IRWrite", IRWrite, e_irw);
      chk("RegW", RegW, e_regw);
      chk("MemToReg", MemToReg, e_m2r);
      chk("regDest", regDest, e_rdst);
      chk("aluSrcA", aluSrcA, e_srca);
      chk("aluSrcB", aluSrcB, e_srcb);
      chk("ALUout", ALUout, e_alu);
      chk("retired", retired, m_ret);
      chk("retired_w4", retired4, {28'd0, m_ret[3:0]});
      chk("illegal", illegal, m_ill);
      if (MemW) memw_hi++;
    end
  end

  task automatic set_in(input logic r, input logic [5:0] op, input logic mr, input logic z);
    reset = r; opcode = op; mem_ready = mr; zero = z;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    set_in(1, LW, 0, 0);
    tick(1);
    // Walk into MEMRD, stall, then reset mid-wait.
    set_in(0, LW, 1, 0); tick(3);
    chk("pre_reset_memrd", state, 3);
    set_in(0, LW, 0, 0); tick(2);
    chk("memrd_hold", state, 3);
    set_in(1, LW, 0, 0); tick(2);
    set_in(0, LW, 1, 0);
    chk("rst_state", state, 0);
    chk("rst_retired", retired, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_MemR", MemR, 1);
    chk("rst_IorD", IorD, 0);

    // lw: 5 cycles, writeback in state 4
    tick(4);
    chk("lw_wb_state", state, 4);
    chk("lw_wb_ctl", {RegW, MemToReg, regDest}, 3'b111);
    tick(1);
    chk("lw_done_state", state, 0);
    chk("lw_retired", retired, 1);

    // sw with three wait cycles in MEMWR
    set_in(0, SW, 1, 0); tick(3);
    chk("sw_memwr", state, 5);
    set_in(0, SW, 0, 0); tick(3);
    chk("sw_hold_ctl", {MemW, IorD, RegW}, 3'b110);
    chk("sw_hold_retired", retired, 1);
    set_in(0, SW, 1, 0); tick(1);
    chk("sw_done_state", state, 0);
    chk("sw_memw_cycles", memw_hi, 4);
    chk("sw_retired", retired, 2);

    // R-type then addi
    set_in(0, RT, 1, 0); tick(2);
    chk("rt_exec_alu", ALUout, 2'b10);
    tick(1);
    chk("rt_wb_regdest", {RegW, regDest}, 2'b10);
    tick(1);
    set_in(0, ADDI, 1, 0); tick(3);
    chk("addi_wb_state", state, 10);
    chk("addi_wb_regdest", regDest, 1);
    tick(1);
    chk("rt_addi_retired", retired, 4);

    // beq taken and not taken, 3 cycles each
    set_in(0, BEQ, 1, 1); tick(2);
    chk("beq_z1_ctl", {PCWriteCond, PCSrc, ALUout}, 4'b1101);
    tick(1);
    chk("beq_z1_back", state, 0);
    set_in(0, BEQ, 1, 0); tick(2);
    chk("beq_z0_ctl", {PCWriteCond, PCSrc, ALUout}, 4'b1101);
    tick(1);
    chk("beq_retired", retired, 6);

    // illegal opcode is sticky and does not retire
    set_in(0, BAD, 1, 0); tick(2);
    chk("bad_state", state, 0);
    chk("bad_illegal", illegal, 1);
    chk("bad_retired", retired, 6);
    set_in(0, RT, 1, 0); tick(4);
    chk("bad_sticky", illegal, 1);
    chk("after_bad_retired", retired, 7);

    // 16 retires wrap the 4-bit counter
    set_in(0, BEQ, 1, 0);
    for (int i = 0; i < 9; i++) tick(3);
    chk("wrap_retired32", retired, 16);
    chk("wrap_retired4", retired4, 0);
    tick(3);
    chk("wrap_retired4_next", retired4, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS datapath; supersedes single-cycle opcode decode for the shared-memory build.
- Steps a single ALU, register file and unified instruction/data memory through fetch, decode, execute, memory and writeback states per instruction.
- Waits on a memory ready handshake.
- Keeps retired-instruction and illegal-opcode status for debug.

Parameters:
- COUNT_W, 32, width of retired-instruction counter.
- OP_RTYPE, 6'b000000, R-type opcode.
- OP_LW, 6'b100011, load word opcode.
- OP_SW, 6'b101011, store word opcode.
- OP_BEQ, 6'b000100, branch-equal opcode.
- OP_ADDI, 6'b001000, add-immediate opcode.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- opcode  in  6  instruction[31:26] from instruction register; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if zero
- PCSrc  out  1  0 = ALU result (PC+4), 1 = branch target register
- IorD  out  1  0 = PC addresses memory, 1 = ALU-out register
- MemR  out  1  memory read request
- MemW  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegW  out  1  register file write
- MemToReg  out  1  1 = memory data register to writeback
- regDest  out  1  0 = rd field, 1 = rt field
- aluSrcA  out  1  0 = PC, 1 = register A
- aluSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUout  out  2  00 add, 01 subtract, 10 decode from funct
- state  out  4  current state encoding, debug
- retired  out  COUNT_W  instructions completed since reset
- illegal  out  1  sticky: unsupported opcode decoded

Behaviour:
- Register state, retired and illegal on rising clk. All control outputs decode combinationally from state; IRWrite/PCWrite additionally gated by mem_ready in FETCH.
- Any output not listed for a state is 0.
- Reset (synchronous, any state, including mid-memory-wait): state = FETCH(0), retired = 0, illegal = 0. Outputs are then FETCH decode: MemR = 1, IorD = 0, aluSrcA = 0, aluSrcB = 01, ALUout = 00, IRWrite = PCWrite = mem_ready.
- FETCH (0): outputs as above. Stay in FETCH while mem_ready = 0; go to DECODE when mem_ready = 1.
- DECODE (1): aluSrcA = 0, aluSrcB = 11, ALUout = 00 (branch target precompute). Next state by opcode:
  - lw/sw -> MEMADR
  - R-type -> EXEC
  - beq -> BRANCH
  - addi -> ADDIEX
  - other -> FETCH, set illegal (no retire)
- MEMADR (2): aluSrcA = 1, aluSrcB = 10, ALUout = 00. lw -> MEMRD; sw -> MEMWR.
- MEMRD (3): MemR = 1, IorD = 1. Hold until mem_ready, then MEMWB.
- MEMWB (4): RegW = 1, MemToReg = 1, regDest = 1. Retire; -> FETCH.
- MEMWR (5): MemW = 1, IorD = 1. Hold until mem_ready, then retire; -> FETCH.
- EXEC (6): aluSrcA = 1, aluSrcB = 00, ALUout = 10. -> ALUWB.
- ALUWB (7): RegW = 1, MemToReg = 0, regDest = 0. Retire; -> FETCH.
- BRANCH (8): aluSrcA = 1, aluSrcB = 00, ALUout = 01, PCWriteCond = 1, PCSrc = 1. Retire regardless of zero; -> FETCH.
- ADDIEX (9): aluSrcA = 1, aluSrcB = 10, ALUout = 00. -> ADDIWB.
- ADDIWB (10): RegW = 1, MemToReg = 0, regDest = 1. Retire; -> FETCH.
- Encodings 11-15 unreachable; if entered, next state = FETCH, no side effects.
- Latencies with mem_ready tied 1, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3.
- retired increments by 1 on the cycle leaving a retiring state; wraps modulo 2^COUNT_W with no flag.
- MemR and MemW never both high. RegW never high in a memory-wait state.

Test Plan:
- Reset held 2 cycles mid-MEMRD -> next cycle state = 0, retired = 0, illegal = 0, MemR = 1, IorD = 0.
- mem_ready = 1, opcode = 100011 -> states 0,1,2,3,4,0; RegW = MemToReg = regDest = 1 only in state 4; retired = 1.
- opcode = 101011, mem_ready low for 3 cycles in MEMWR -> MemW = 1, IorD = 1 held 4 cycles; RegW never 1; retired +1 once.
- opcode = 000000 then 001000 -> ALUout = 10 in EXEC, regDest = 0 in ALUWB; addi gives regDest = 1 in ADDIWB; retired = 2.
- opcode = 000100, zero = 1 then zero = 0 -> PCWriteCond = 1, PCSrc = 1, ALUout = 01 in state 8 both times; 3 cycles each; retired = 2.
- opcode = 111111 -> DECODE to FETCH, illegal = 1 and stays 1 through the next valid instruction; retired unchanged; COUNT_W = 4 with 16 retires -> retired wraps to 0.
